// File: rtl/conv1d_stream_par_if.sv
// conv1d_stream_par_if: valid/ready bundle for the streaming 1-D convolution engine.
//   f_*  filter coefficient load channel (producer -> engine)
//   x_*  input sample channel            (producer -> engine)
//   y_*  output sample channel           (engine -> consumer)
//   master: the side that supplies f/x and consumes y; slave: the engine.
interface conv1d_stream_par_if #(
   parameter int T = 20
);
   logic [T-1:0] f_data;
   logic         f_valid;
   logic         f_ready;
   logic [T-1:0] x_data;
   logic         x_valid;
   logic         x_ready;
   logic [T-1:0] y_data;
   logic         y_valid;
   logic         y_ready;

   modport master (
      output f_data, f_valid, x_data, x_valid, y_ready,
      input  f_ready, x_ready, y_data, y_valid
   );

   modport slave (
      input  f_data, f_valid, x_data, x_valid, y_ready,
      output f_ready, x_ready, y_data, y_valid
   );
endinterface

// File: rtl/conv1d_stream_par.sv
// conv1d_stream_par: streaming valid-mode 1-D convolution with a runtime-loaded filter.
//   clk    clock
//   reset  synchronous, active-high; clears all state including the filter
//   bus    conv1d_stream_par_if.slave
//          f_data/f_valid/f_ready  filter coefficients 0..SIZE_F-1, accepted once per reset
//          x_data/x_valid/x_ready  input samples 0..SIZE_X-1, one vector per LOAD phase
//          y_data/y_valid/y_ready  outputs 0..C-1, C = SIZE_X-SIZE_F+1
//   P lanes compute one output group per SIZE_F cycles with saturating multiply and add;
//   RELU=1 clamps negative results to zero before they are buffered.
module conv1d_stream_par #(
   parameter int T      = 20,
   parameter int SIZE_X = 16,
   parameter int SIZE_F = 4,
   parameter int P      = 2,
   parameter int RELU   = 1
) (
   input logic                clk,
   input logic                reset,
   conv1d_stream_par_if.slave bus
);
   localparam int C  = SIZE_X - SIZE_F + 1;
   localparam int G  = (C + P - 1) / P;
   localparam int XI = $clog2(SIZE_X);
   localparam int FI = $clog2(SIZE_F);
   localparam int CW = C > 1 ? $clog2(C) : 1;
   localparam int GW = G > 1 ? $clog2(G) : 1;
   localparam logic signed [T-1:0] MAXV = {1'b0, {(T-1){1'b1}}};
   localparam logic signed [T-1:0] MINV = {1'b1, {(T-1){1'b0}}};

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

   state_t              state, state_nxt;
   logic signed [T-1:0] f_mem [SIZE_F];
   logic signed [T-1:0] x_mem [SIZE_X];
   logic signed [T-1:0] y_mem [C];
   logic signed [T-1:0] acc [P];
   logic signed [T-1:0] acc_nxt [P];
   logic [FI-1:0]       f_cnt, k;
   logic [XI-1:0]       x_cnt;
   logic [CW-1:0]       y_cnt;
   logic [GW-1:0]       g;
   logic                f_loaded, x_done;
   logic                f_fire, x_fire, y_fire, last_tap, last_group;

   // Full-precision product clamped to T bits: it fits only when the top T+1 bits agree.
   function automatic logic signed [T-1:0] sat_mul(input logic signed [T-1:0] a, input logic signed [T-1:0] b);
      logic signed [2*T-1:0] p;
      p = a * b;
      return (p[2*T-1:T-1] == {(T+1){p[2*T-1]}}) ? p[T-1:0] : (p[2*T-1] ? MINV : MAXV);
   endfunction

   // One guard bit catches overflow of the T-bit add.
   function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a, input logic signed [T-1:0] b);
      logic signed [T:0] s;
      s = {a[T-1], a} + {b[T-1], b};
      return (s[T] == s[T-1]) ? s[T-1:0] : (s[T] ? MINV : MAXV);
   endfunction

   function automatic logic signed [T-1:0] relu(input logic signed [T-1:0] v);
      return (RELU != 0 && v[T-1]) ? '0 : v;
   endfunction

   assign f_fire     = bus.f_valid && bus.f_ready;
   assign x_fire     = bus.x_valid && bus.x_ready;
   assign y_fire     = bus.y_valid && bus.y_ready;
   assign last_tap   = k == FI'(SIZE_F - 1);
   assign last_group = g == GW'(G - 1);

   // Lane l of group g accumulates tap k of output g*P+l. Lanes past C-1 in the last
   // group read a clamped sample address; their results are never written back.
   always_comb begin
      int xi;
      xi = 0;
      for (int l = 0; l < P; l++) begin
         xi = int'(g) * P + l + int'(k);
         xi = xi > SIZE_X - 1 ? SIZE_X - 1 : xi;
         acc_nxt[l] = sat_add(k == '0 ? MAXV ^ MAXV : acc[l], sat_mul(x_mem[XI'(xi)], f_mem[k]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LOAD;
         f_cnt    <= '0;
         x_cnt    <= '0;
         y_cnt    <= '0;
         g        <= '0;
         k        <= '0;
         f_loaded <= 1'b0;
         x_done   <= 1'b0;
         for (int l = 0; l < P; l++) acc[l] <= '0;
      end else begin
         state <= state_nxt;
         if (f_fire) begin
            f_mem[f_cnt] <= bus.f_data;
            f_cnt        <= f_cnt + 1'b1;
            if (f_cnt == FI'(SIZE_F - 1)) f_loaded <= 1'b1;
         end
         if (x_fire) begin
            x_mem[x_cnt] <= bus.x_data;
            x_cnt        <= x_cnt == XI'(SIZE_X - 1) ? '0 : x_cnt + 1'b1;
            if (x_cnt == XI'(SIZE_X - 1)) x_done <= 1'b1;
         end
         if (state == COMPUTE) begin
            for (int l = 0; l < P; l++) acc[l] <= acc_nxt[l];
            k <= last_tap ? '0 : k + 1'b1;
            if (last_tap) begin
               g <= last_group ? '0 : g + 1'b1;
               for (int l = 0; l < P; l++)
                  if (int'(g) * P + l < C) y_mem[CW'(int'(g) * P + l)] <= relu(acc_nxt[l]);
            end
         end
         // Releasing x_done on the final output reopens the x port; the filter stays loaded.
         if (y_fire) begin
            y_cnt <= y_cnt == CW'(C - 1) ? '0 : y_cnt + 1'b1;
            if (y_cnt == CW'(C - 1)) x_done <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (f_loaded && x_done) state_nxt = COMPUTE;
         COMPUTE: if (last_tap && last_group) state_nxt = DRAIN;
         DRAIN:   if (y_fire && y_cnt == CW'(C - 1)) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_comb begin
      bus.f_ready = !f_loaded;
      bus.x_ready = state == LOAD && !x_done;
      bus.y_valid = state == DRAIN;
      bus.y_data  = state == DRAIN ? y_mem[y_cnt] : '0;
   end
endmodule

// File: tb/tb_conv1d_stream_par.sv
// tb_conv1d_stream_par: directed bench for conv1d_stream_par.
//   Two engines share one stimulus stream: u_relu (RELU=1) and u_lin (RELU=0).
module tb_conv1d_stream_par;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   conv1d_stream_par_if #(.T(20)) b0 ();
   conv1d_stream_par_if #(.T(20)) b1 ();

   assign b1.f_data  = b0.f_data;
   assign b1.f_valid = b0.f_valid;
   assign b1.x_data  = b0.x_data;
   assign b1.x_valid = b0.x_valid;
   assign b1.y_ready = b0.y_ready;

   conv1d_stream_par #(.RELU(1)) u_relu (.clk(clk), .reset(reset), .bus(b0));
   conv1d_stream_par #(.RELU(0)) u_lin  (.clk(clk), .reset(reset), .bus(b1));

   int          vectors = 0;
   int          errs = 0;
   int          ntx;
   logic [19:0] fv [4];
   logic [19:0] xv [16];
   logic [19:0] got0 [13];
   logic [19:0] got1 [13];

   task automatic check(input string tag, input integer obs, input integer exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      b0.f_valid = 1'b0;
      b0.x_valid = 1'b0;
      b0.y_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_f();
      for (int i = 0; i < 4; i++) begin
         int t = 0;
         @(negedge clk);
         b0.f_data  = fv[i];
         b0.f_valid = 1'b1;
         while (!b0.f_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("f_ready_wait", integer'(b0.f_ready), 1);
      end
      @(negedge clk);
      b0.f_valid = 1'b0;
   endtask

   task automatic send_x();
      for (int i = 0; i < 16; i++) begin
         int t = 0;
         @(negedge clk);
         b0.x_data  = xv[i];
         b0.x_valid = 1'b1;
         while (!b0.x_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         check("x_ready_wait", integer'(b0.x_ready), 1);
      end
      @(negedge clk);
      b0.x_valid = 1'b0;
   endtask

   task automatic recv(input bit rnd);
      int          t = 0;
      logic [19:0] held = '0;
      bit          stalled = 1'b0;
      ntx = 0;
      while (ntx < 13 && t < 3000) begin
         @(negedge clk);
         t++;
         if (stalled) begin
            check("stall_valid", integer'(b0.y_valid), 1);
            check("stall_data", $signed(b0.y_data), $signed(held));
         end
         b0.y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = b0.y_valid && !b0.y_ready;
         held = b0.y_data;
         if (b0.y_valid && b0.y_ready) begin
            got0[ntx] = b0.y_data;
            got1[ntx] = b1.y_data;
            ntx++;
         end
      end
      check("y_count", ntx, 13);
      @(negedge clk);
      b0.y_ready = 1'b0;
      check("y_valid_after_last", integer'(b0.y_valid), 0);
      check("x_ready_after_last", integer'(b0.x_ready), 1);
   endtask

   initial begin
      b0.f_data  = '0;
      b0.f_valid = 1'b0;
      b0.x_data  = '0;
      b0.x_valid = 1'b0;
      b0.y_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_f_ready", integer'(b0.f_ready), 1);
      check("rst_x_ready", integer'(b0.x_ready), 1);
      check("rst_y_valid", integer'(b0.y_valid), 0);
      check("rst_y_data", integer'(b0.y_data), 0);

      // f=[1,2,3,4], x=0..15, loads overlapping: y[i]=10i+20
      fv = '{20'd1, 20'd2, 20'd3, 20'd4};
      for (int i = 0; i < 16; i++) xv[i] = 20'(i);
      fork
         send_f();
         send_x();
      join
      recv(1'b0);
      for (int i = 0; i < 13; i++) begin
         check($sformatf("ramp_y%0d", i), $signed(got0[i]), 10 * i + 20);
         check($sformatf("ramp_lin_y%0d", i), $signed(got1[i]), 10 * i + 20);
      end
      check("f_ready_after_load", integer'(b0.f_ready), 0);

      // Second vector with retained filter, x=15..0: y[i]=130-10i
      for (int i = 0; i < 16; i++) xv[i] = 20'(15 - i);
      send_x();
      recv(1'b0);
      for (int i = 0; i < 13; i++) check($sformatf("rev_y%0d", i), $signed(got0[i]), 130 - 10 * i);

      // Third vector, random consumer stalls: same sequence as the unstalled ramp
      for (int i = 0; i < 16; i++) xv[i] = 20'(i);
      send_x();
      recv(1'b1);
      for (int i = 0; i < 13; i++) check($sformatf("stall_y%0d", i), $signed(got0[i]), 10 * i + 20);

      // f all -1, x all 1: linear gives -4, ReLU gives 0
      do_reset();
      check("rst2_f_ready", integer'(b0.f_ready), 1);
      fv = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
      for (int i = 0; i < 16; i++) xv[i] = 20'd1;
      fork
         send_f();
         send_x();
      join
      recv(1'b0);
      for (int i = 0; i < 13; i++) begin
         check($sformatf("neg_relu_y%0d", i), $signed(got0[i]), 0);
         check($sformatf("neg_lin_y%0d", i), $signed(got1[i]), -4);
      end

      // Saturation: every product and sum clamps to the positive limit
      do_reset();
      fv = '{20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF};
      for (int i = 0; i < 16; i++) xv[i] = 20'h7FFFF;
      fork
         send_f();
         send_x();
      join
      recv(1'b0);
      for (int i = 0; i < 13; i++) begin
         check($sformatf("sat_y%0d", i), $signed(got0[i]), 524287);
         check($sformatf("sat_lin_y%0d", i), $signed(got1[i]), 524287);
      end

      // Reset mid-COMPUTE, then a fresh identity filter: y[i]=i
      do_reset();
      fv = '{20'd1, 20'd2, 20'd3, 20'd4};
      for (int i = 0; i < 16; i++) xv[i] = 20'(i);
      fork
         send_f();
         send_x();
      join
      repeat (6) @(negedge clk);
      check("mid_compute_x_ready", integer'(b0.x_ready), 0);
      check("mid_compute_y_valid", integer'(b0.y_valid), 0);
      do_reset();
      check("midrst_f_ready", integer'(b0.f_ready), 1);
      check("midrst_x_ready", integer'(b0.x_ready), 1);
      check("midrst_y_valid", integer'(b0.y_valid), 0);
      fv = '{20'd1, 20'd0, 20'd0, 20'd0};
      fork
         send_f();
         send_x();
      join
      check("no_stale_y_valid", integer'(b0.y_valid), 0);
      recv(1'b0);
      for (int i = 0; i < 13; i++) check($sformatf("ident_y%0d", i), $signed(got0[i]), i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
